// File: rtl/fret_hit_judge.sv
// fret_hit_judge -- strum-window hit/miss judge for a five-lane rhythm game.
//
// A key press (rising edge of a lane's keycode match) is judged against the
// lane's note position. The note counts only while it is inside the strum
// window and not already consumed. Hits feed a saturating combo counter and a
// per-player 0..99 score, and the score is presented as 2-digit BCD.
//
// Optional feature macro: JUDGE_COMBO_MULT_EN
//   When defined, each hit is worth 2 points while the combo (before this
//   pass's update) is >= 10. Otherwise every hit is worth 1 point.
//
// Ports
//   Clk            in   1   system clock (sole clock)
//   Reset          in   1   synchronous, active-high reset
//   keycode        in  16   two USB keycodes [7:0],[15:8]; 8'h00 = no key
//   *_y_pos        in  10   note top y for lanes G,R,Y,B,O (0..4)
//   player_flag    in   1   active player (0 = P1, 1 = P2), sampled in JUDGE
//   hit_pulse      out  5   one-cycle per-lane hit strobe
//   miss_pulse     out  1   one-cycle miss strobe
//   combo          out  8   consecutive hits, saturates at 255
//   score_1/2      out  8   per-player packed BCD {tens, ones}
module fret_hit_judge #(
  parameter logic [9:0] HIT_LO = 10'd400,
  parameter logic [9:0] HIT_HI = 10'd460,
  parameter logic [7:0] KEY_G  = 8'h04,
  parameter logic [7:0] KEY_R  = 8'h16,
  parameter logic [7:0] KEY_Y  = 8'h07,
  parameter logic [7:0] KEY_B  = 8'h09,
  parameter logic [7:0] KEY_O  = 8'h0A
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [9:0]  green_y_pos,
  input  logic [9:0]  red_y_pos,
  input  logic [9:0]  yellow_y_pos,
  input  logic [9:0]  blue_y_pos,
  input  logic [9:0]  orange_y_pos,
  input  logic        player_flag,
  output logic [4:0]  hit_pulse,
  output logic        miss_pulse,
  output logic [7:0]  combo,
  output logic [7:0]  score_1,
  output logic [7:0]  score_2
);

  typedef enum logic [1:0] {S_IDLE, S_JUDGE, S_UPDATE} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_press_q, r_lock, r_pend, r_hits;
  logic        r_miss_any, r_player, r_rst_q;
  logic [4:0]  r_hit_pulse;
  logic        r_miss_pulse;
  logic [7:0]  r_combo;
  logic [6:0]  r_s1, r_s2;
  logic [7:0]  r_bcd1, r_bcd2;

  logic [4:0][7:0] w_key;
  logic [4:0][9:0] w_ypos;
  logic [4:0]  w_pressed, w_inwin_raw, w_eff, w_rise, w_hits, w_misses;
  logic [4:0]  w_pend_nxt;
  logic        w_do_judge, w_do_update;

  assign w_key  = {KEY_O, KEY_B, KEY_Y, KEY_R, KEY_G};
  assign w_ypos = {orange_y_pos, blue_y_pos, yellow_y_pos, red_y_pos, green_y_pos};

  for (genvar i = 0; i < 5; i++) begin : g_lane
    assign w_pressed[i]   = (keycode[7:0] == w_key[i]) | (keycode[15:8] == w_key[i]);
    assign w_inwin_raw[i] = (w_ypos[i] >= HIT_LO) && (w_ypos[i] <= HIT_HI);
  end

  // The cycle right after reset only re-samples the keys, so a key held
  // through reset is not mistaken for a fresh press.
  assign w_rise   = w_pressed & ~r_press_q & {5{~r_rst_q}};
  // A consumed note stays unavailable until it leaves the window.
  assign w_eff    = w_inwin_raw & ~r_lock;
  assign w_hits   = r_pend & w_eff;
  assign w_misses = r_pend & ~w_eff;

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    popcnt5 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    logic [6:0] t, o;
    t = b / 7'd10;
    o = b - t * 7'd10;
    bin2bcd = {t[3:0], o[3:0]};
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if ((r_pend | w_rise) != 5'd0) w_state_nxt = S_JUDGE;
      S_JUDGE:  w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / pending-rise control ----------------
  // JUDGE consumes the pending set; rises seen meanwhile wait for next pass.
  always_comb begin
    w_pend_nxt  = r_pend | w_rise;
    w_do_judge  = 1'b0;
    w_do_update = 1'b0;
    case (r_state)
      S_JUDGE: begin
        w_pend_nxt = w_rise;
        w_do_judge = 1'b1;
      end
      S_UPDATE: w_do_update = 1'b1;
      default: ;
    endcase
  end

  // ---------------- scoring arithmetic ----------------
  logic [2:0] w_pc;
  logic       w_mult;
  logic [3:0] w_add;
  logic [6:0] w_sc_base, w_sc_new;
  logic [7:0] w_sc_sum;
  logic [8:0] w_cmb_sum;
  logic [7:0] w_cmb_new;

  assign w_pc = popcnt5(r_hits);
`ifdef JUDGE_COMBO_MULT_EN
  assign w_mult = (r_combo >= 8'd10);
`else
  assign w_mult = 1'b0;
`endif
  assign w_add     = w_mult ? {w_pc, 1'b0} : {1'b0, w_pc};
  assign w_sc_base = r_player ? r_s2 : r_s1;
  assign w_sc_sum  = {1'b0, w_sc_base} + {4'd0, w_add};
  assign w_sc_new  = (w_sc_sum > 8'd99) ? 7'd99 : w_sc_sum[6:0];
  assign w_cmb_sum = {1'b0, r_combo} + {6'd0, w_pc};
  assign w_cmb_new = r_miss_any ? 8'd0 : (w_cmb_sum[8] ? 8'hFF : w_cmb_sum[7:0]);

  // ---------------- datapath ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_press_q    <= 5'd0;
      r_lock       <= 5'd0;
      r_pend       <= 5'd0;
      r_hits       <= 5'd0;
      r_miss_any   <= 1'b0;
      r_player     <= 1'b0;
      r_rst_q      <= 1'b1;
      r_hit_pulse  <= 5'd0;
      r_miss_pulse <= 1'b0;
      r_combo      <= 8'd0;
      r_s1         <= 7'd0;
      r_s2         <= 7'd0;
      r_bcd1       <= 8'd0;
      r_bcd2       <= 8'd0;
    end else begin
      r_rst_q   <= 1'b0;
      r_press_q <= w_pressed;
      r_pend    <= w_pend_nxt;
      // Lock is set by a hit and dropped on any cycle out of window.
      r_lock    <= (r_lock | (w_do_judge ? w_hits : 5'd0)) & w_inwin_raw;
      if (w_do_judge) begin
        r_hits     <= w_hits;
        r_miss_any <= |w_misses;
        r_player   <= player_flag;
      end
      r_hit_pulse  <= w_do_update ? r_hits : 5'd0;
      r_miss_pulse <= w_do_update & r_miss_any;
      if (w_do_update) begin
        r_combo <= w_cmb_new;
        if (r_player) r_s2 <= w_sc_new;
        else          r_s1 <= w_sc_new;
      end
      r_bcd1 <= bin2bcd(r_s1);
      r_bcd2 <= bin2bcd(r_s2);
    end
  end

  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign combo      = r_combo;
  assign score_1    = r_bcd1;
  assign score_2    = r_bcd2;

endmodule
